led_burst_driver: RTL and testbench

//   Output-side counterpart to the debounced push-button inputs: drives one active-low board LED.

---
 rtl/led_pkg.sv | 18 +
 rtl/led_phase_timer.sv | 33 +++
 rtl/led_burst_driver.sv | 132 +++++++++++++
 tb/tb_led_burst_driver.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared encodings for the LED burst driver: mode select values and burst FSM states.
package led_pkg;

   localparam int unsigned MODE_W = 2;

   localparam logic [MODE_W-1:0] MODE_OFF   = 2'b00;
   localparam logic [MODE_W-1:0] MODE_SOLID = 2'b01;
   localparam logic [MODE_W-1:0] MODE_BLINK = 2'b10;
   localparam logic [MODE_W-1:0] MODE_BURST = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ON_PH  = 2'b01,
      ST_OFF_PH = 2'b10,
      ST_DONE   = 2'b11
   } burst_state_e;

endpackage

// File: rtl/led_phase_timer.sv
// Free-running phase counter with synchronous clear; flags the last cycle of each half period.
module led_phase_timer #(
   parameter int unsigned HALF_PERIOD = 12_500_000,
   parameter int unsigned CNT_W       = 24
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   output logic wrap_c_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign wrap_c_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clr_i || wrap_c_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_burst_driver.sv
// Active-low LED driver: OFF, SOLID, 50% BLINK, or a counted BURST of flashes with busy/done handshake.
module led_burst_driver
   import led_pkg::*;
#(
   parameter int unsigned HALF_PERIOD = 12_500_000,
   parameter int unsigned CNT_W       = 24,
   parameter int unsigned BURST_W     = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [MODE_W-1:0]  mode_i,
   input  logic               start_i,
   input  logic [BURST_W-1:0] burst_len_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               led_n_o
);

   burst_state_e       state_q, state_d;
   logic [MODE_W-1:0]  mode_q;
   logic [BURST_W-1:0] flash_q, flash_d;
   logic               led_n_q, led_n_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               mode_chg_c;
   logic               tmr_clr_c;
   logic               wrap_c;

   assign mode_chg_c = (mode_i != mode_q);

   led_phase_timer #(
      .HALF_PERIOD (HALF_PERIOD),
      .CNT_W       (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (tmr_clr_c),
      .wrap_c_o (wrap_c)
   );

   // Mode decode and burst sequencing; leaving BURST forces the FSM back to IDLE.
   always_comb begin
      state_d   = ST_IDLE;
      flash_d   = '0;
      led_n_d   = 1'b1;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      tmr_clr_c = mode_chg_c;

      case (mode_i)
         MODE_SOLID: begin
            led_n_d = 1'b0;
         end
         MODE_BLINK: begin
            led_n_d = mode_chg_c ? 1'b0 : (led_n_q ^ wrap_c);
         end
         MODE_BURST: begin
            state_d = state_q;
            flash_d = flash_q;
            case (state_q)
               ST_IDLE: begin
                  if (start_i) begin
                     tmr_clr_c = 1'b1;
                     busy_d    = 1'b1;
                     if (burst_len_i == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                     end else begin
                        state_d = ST_ON_PH;
                        flash_d = burst_len_i;
                        led_n_d = 1'b0;
                     end
                  end
               end
               ST_ON_PH: begin
                  busy_d  = 1'b1;
                  led_n_d = 1'b0;
                  if (wrap_c) begin
                     state_d = ST_OFF_PH;
                     led_n_d = 1'b1;
                  end
               end
               ST_OFF_PH: begin
                  busy_d = 1'b1;
                  if (wrap_c) begin
                     flash_d = flash_q - BURST_W'(1);
                     if (flash_q == BURST_W'(1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                     end else begin
                        state_d = ST_ON_PH;
                        led_n_d = 1'b0;
                     end
                  end
               end
               ST_DONE: begin
                  state_d = ST_IDLE;
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end
         default: begin
            led_n_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_OFF;
         flash_q <= '0;
         led_n_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_i;
         flash_q <= flash_d;
         led_n_q <= led_n_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign led_n_o = led_n_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_led_burst_driver.sv
// Directed bench for led_burst_driver with a per-cycle arithmetic reference model (HALF_PERIOD=4).
module tb_led_burst_driver;

   localparam int HP = 4;

   logic       clk;
   logic       rst_n;
   logic [1:0] mode_i;
   logic       start_i;
   logic [3:0] burst_len_i;
   logic       busy_o;
   logic       done_o;
   logic       led_n_o;

   int vectors = 0;
   int fails   = 0;
   bit chk_en  = 0;

   led_burst_driver #(
      .HALF_PERIOD (HP),
      .CNT_W       (3),
      .BURST_W     (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mode_i      (mode_i),
      .start_i     (start_i),
      .burst_len_i (burst_len_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .led_n_o     (led_n_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: outputs as a function of cycles elapsed since mode entry or burst start.
   int cyc, entry, bstart, bn, prev_mode, mk;
   bit bact;
   bit e_led, e_busy, e_done;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc = 0; entry = 0; prev_mode = 0; bact = 0;
         e_led = 1; e_busy = 0; e_done = 0;
      end else begin
         cyc++;
         if (int'(mode_i) != prev_mode) entry = cyc;
         prev_mode = int'(mode_i);
         e_led = 1; e_busy = 0; e_done = 0;
         if (mode_i != 2'd3) bact = 0;
         case (mode_i)
            2'd1: e_led = 0;
            2'd2: e_led = (((cyc - entry) / HP) % 2) != 0;
            2'd3: begin
               if (bact && (cyc - bstart) > 2 * bn * HP + 1) bact = 0;
               if (!bact && start_i) begin
                  bact = 1; bstart = cyc; bn = int'(burst_len_i);
               end
               if (bact) begin
                  mk = cyc - bstart;
                  if (mk < 2 * bn * HP) begin
                     e_busy = 1; e_led = ((mk / HP) % 2) != 0;
                  end else if (mk == 2 * bn * HP) begin
                     e_busy = 1; e_done = 1;
                  end
               end
            end
            default: e_led = 1;
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         chk("model_led",  int'(led_n_o), int'(e_led));
         chk("model_busy", int'(busy_o),  int'(e_busy));
         chk("model_done", int'(done_o),  int'(e_done));
      end
   end

   logic pat [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   int busy_cnt, done_cnt, done_at;

   initial begin
      rst_n = 0; mode_i = 2'd0; start_i = 0; burst_len_i = 4'd0;
      repeat (3) @(negedge clk);
      chk("rst_led", int'(led_n_o), 1);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_done", int'(done_o), 0);
      rst_n = 1;
      chk_en = 1;
      @(negedge clk);

      // Blink: 4 low, 4 high, three periods
      mode_i = 2'd2;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         chk("blink_pat", int'(led_n_o), int'(pat[i % 8]));
      end

      // Async reset mid-blink while the LED is lit
      @(posedge clk);
      #3;
      chk("pre_rst_lit", int'(led_n_o), 0);
      rst_n = 0;
      #1;
      chk("async_rst_led", int'(led_n_o), 1);
      chk("async_rst_busy", int'(busy_o), 0);
      chk("async_rst_done", int'(done_o), 0);
      mode_i = 2'd0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_led", int'(led_n_o), 1);
         chk("post_rst_busy", int'(busy_o), 0);
      end

      // Burst of 3
      mode_i = 2'd3;
      @(negedge clk);
      start_i = 1; burst_len_i = 4'd3;
      busy_cnt = 0; done_cnt = 0; done_at = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 0) begin
            start_i = 0;
            chk("burst3_first_led", int'(led_n_o), 0);
         end
         if (i == 4) chk("burst3_off_led", int'(led_n_o), 1);
         busy_cnt += int'(busy_o);
         if (done_o) begin
            done_cnt++;
            done_at = i + 1;
         end
      end
      chk("burst3_busy_cycles", busy_cnt, 25);
      chk("burst3_done_count", done_cnt, 1);
      chk("burst3_done_cycle", done_at, 25);
      chk("burst3_led_after", int'(led_n_o), 1);

      // Zero-length burst
      start_i = 1; burst_len_i = 4'd0;
      @(negedge clk);
      start_i = 0;
      chk("len0_busy", int'(busy_o), 1);
      chk("len0_done", int'(done_o), 1);
      chk("len0_led", int'(led_n_o), 1);
      @(negedge clk);
      chk("len0_busy_end", int'(busy_o), 0);
      chk("len0_done_end", int'(done_o), 0);
      repeat (2) @(negedge clk);

      // Burst of 5: re-pulse ignored, then abort to SOLID during the 2nd flash
      start_i = 1; burst_len_i = 4'd5;
      @(negedge clk);
      start_i = 0;
      @(negedge clk);
      start_i = 1; burst_len_i = 4'd2;
      @(negedge clk);
      start_i = 0;
      repeat (7) @(negedge clk);
      chk("b5_flash2_led", int'(led_n_o), 0);
      chk("b5_flash2_busy", int'(busy_o), 1);
      mode_i = 2'd1;
      @(negedge clk);
      chk("abort_busy", int'(busy_o), 0);
      chk("abort_led", int'(led_n_o), 0);
      chk("abort_done", int'(done_o), 0);
      repeat (45) @(negedge clk);

      // SOLID -> OFF -> BLINK on consecutive cycles
      mode_i = 2'd0;
      @(negedge clk);
      chk("m6_off_led", int'(led_n_o), 1);
      mode_i = 2'd2;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("m6_blink_pat", int'(led_n_o), int'(pat[i % 8]));
      end

      // Start coinciding with a mode change away from BURST is dropped
      mode_i = 2'd3;
      @(negedge clk);
      mode_i = 2'd0; start_i = 1; burst_len_i = 4'd2;
      @(negedge clk);
      start_i = 0;
      chk("drop_start_busy", int'(busy_o), 0);
      mode_i = 2'd3;
      repeat (10) @(negedge clk);
      chk("drop_start_idle", int'(busy_o), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
